// File: rtl/serializer.sv
// Splits one captured message into a header beat plus NUMBER_PACKET payload beats on an AXI-Stream style Aurora TX port.
// Optional build macro SERIALIZER_HDR_CHECKSUM_EN adds an XOR-of-all-bytes checksum to the header beat.
//
// state   | meaning
// IDLE    | waiting for send_data_valid; captures the message on acceptance
// HEADER  | header beat on the bus, frame_count = 0
// PAYLOAD | payload beat frame_count-1 on the bus, frame_count = 1..NUMBER_PACKET
// DONE    | one-cycle done_serializer pulse, bus idle
module serializer #(
  parameter int NUMER_OF_LANE          = 1,
  parameter int AURORA_DATA_WIDTH      = 64*NUMER_OF_LANE,
  parameter int SEND_DATA_WIDTH        = 1024,
  parameter int RECOGNIZE_HEADER_WIDTH = 1,
  parameter int RECOGNIZE_ROUTER_WIDTH = 2,
  parameter int HOST_PAYLOAD_WIDTH     = AURORA_DATA_WIDTH-3,
  parameter int NUMBER_PACKET          = SEND_DATA_WIDTH/HOST_PAYLOAD_WIDTH+1,
  parameter int ADDR_WIDTH             = 10,
  parameter int NUMBER_OF_TTL          = 1,
  parameter int TTL_WIDTH              = $clog2(NUMBER_OF_TTL)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         send_data_valid,
  input  logic [SEND_DATA_WIDTH-1:0]   v_data_read,
  input  logic [ADDR_WIDTH-1:0]        dst_addr_send,
  input  logic [1:0]                   TTL_send,
  input  logic [1:0]                   router_id_send,
  output logic                         axis_tx_tvalid,
  output logic                         axis_tx_tlast,
  output logic [AURORA_DATA_WIDTH-1:0] axis_tx_tdata,
  output logic                         done_serializer
);

  localparam int ROUTER_LSB  = RECOGNIZE_HEADER_WIDTH;
  localparam int PAYLOAD_LSB = RECOGNIZE_HEADER_WIDTH + RECOGNIZE_ROUTER_WIDTH;
  localparam int TTL_LSB     = PAYLOAD_LSB + ADDR_WIDTH;
  localparam int PAD_W       = NUMBER_PACKET * HOST_PAYLOAD_WIDTH;
  localparam int OFS_W       = $clog2(PAD_W);
  localparam logic [4:0] FRAME_LAST = 5'(NUMBER_PACKET);

  if (TTL_WIDTH > 2) begin : g_ttl_chk
    $error("TTL_WIDTH does not fit the fixed 2-bit TTL field");
  end

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DONE} state_e;

  state_e                         state_q, state_d;
  logic [4:0]                     frame_count_q, frame_count_d;
  logic [SEND_DATA_WIDTH-1:0]     data_q, data_d;
  logic [ADDR_WIDTH-1:0]          dst_q, dst_d;
  logic [1:0]                     ttl_q, ttl_d;
  logic [1:0]                     rid_q, rid_d;

  logic                           tvalid_q, tvalid_d;
  logic                           tlast_q, tlast_d;
  logic                           done_q, done_d;
  logic [AURORA_DATA_WIDTH-1:0]   tdata_q, tdata_d;

  logic [PAD_W-1:0]               data_pad;
  logic [4:0]                     beat_idx;
  logic [OFS_W-1:0]               beat_ofs;
  logic [HOST_PAYLOAD_WIDTH-1:0]  beat_payload;

  always_comb begin
    state_d       = state_q;
    frame_count_d = frame_count_q;
    data_d        = data_q;
    dst_d         = dst_q;
    ttl_d         = ttl_q;
    rid_d         = rid_q;
    case (state_q)
      IDLE: begin
        if (send_data_valid) begin
          state_d       = HEADER;
          frame_count_d = 5'd0;
          data_d        = v_data_read;
          dst_d         = dst_addr_send;
          ttl_d         = TTL_send;
          rid_d         = router_id_send;
        end
      end
      HEADER: begin
        state_d       = PAYLOAD;
        frame_count_d = 5'd1;
      end
      PAYLOAD: begin
        if (frame_count_q == FRAME_LAST) begin
          state_d       = DONE;
          frame_count_d = 5'd0;
        end else begin
          frame_count_d = frame_count_q + 5'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are built from next-state values so the registered beat lines up
  // with the state it belongs to (header lands one cycle after acceptance).
  // The message is zero-extended so the final short beat pads with zeros.
  assign data_pad     = PAD_W'(data_d);
  assign beat_idx     = (frame_count_d == 5'd0) ? 5'd0 : frame_count_d - 5'd1;
  assign beat_ofs     = OFS_W'(beat_idx) * OFS_W'(HOST_PAYLOAD_WIDTH);
  assign beat_payload = data_pad[beat_ofs +: HOST_PAYLOAD_WIDTH];

`ifdef SERIALIZER_HDR_CHECKSUM_EN
  logic [7:0] csum;

  always_comb begin
    csum = 8'h00;
    for (int i = 0; i < SEND_DATA_WIDTH/8; i++) begin
      csum = csum ^ data_d[i*8 +: 8];
    end
  end
`endif

  always_comb begin
    tvalid_d = 1'b0;
    tlast_d  = 1'b0;
    done_d   = 1'b0;
    tdata_d  = '0;
    case (state_d)
      HEADER: begin
        tvalid_d                                      = 1'b1;
        tdata_d[0 +: RECOGNIZE_HEADER_WIDTH]          = RECOGNIZE_HEADER_WIDTH'(1);
        tdata_d[ROUTER_LSB +: RECOGNIZE_ROUTER_WIDTH] = rid_d;
        tdata_d[PAYLOAD_LSB +: ADDR_WIDTH]            = dst_d;
        tdata_d[TTL_LSB +: 2]                         = ttl_d;
`ifdef SERIALIZER_HDR_CHECKSUM_EN
        tdata_d[TTL_LSB+2 +: 8]                       = csum;
`endif
      end
      PAYLOAD: begin
        tvalid_d                                      = 1'b1;
        tlast_d                                       = (frame_count_d == FRAME_LAST);
        tdata_d[ROUTER_LSB +: RECOGNIZE_ROUTER_WIDTH] = rid_d;
        tdata_d[PAYLOAD_LSB +: HOST_PAYLOAD_WIDTH]    = beat_payload;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      frame_count_q <= 5'd0;
      data_q        <= '0;
      dst_q         <= '0;
      ttl_q         <= 2'd0;
      rid_q         <= 2'd0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      done_q        <= 1'b0;
      tdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      frame_count_q <= frame_count_d;
      data_q        <= data_d;
      dst_q         <= dst_d;
      ttl_q         <= ttl_d;
      rid_q         <= rid_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      done_q        <= done_d;
      tdata_q       <= tdata_d;
    end
  end

  assign axis_tx_tvalid  = tvalid_q;
  assign axis_tx_tlast   = tlast_q;
  assign axis_tx_tdata   = tdata_q;
  assign done_serializer = done_q;

endmodule

// File: tb/tb_serializer.sv
// Scoreboard bench for serializer: expected beats are queued at request time and
// popped by a negedge monitor; also checks run length, done pulse and reset behaviour.
module tb_serializer;

  logic          clk;
  logic          rst_n;
  logic          send_data_valid;
  logic [1023:0] v_data_read;
  logic [9:0]    dst_addr_send;
  logic [1:0]    TTL_send;
  logic [1:0]    router_id_send;
  logic          axis_tx_tvalid;
  logic          axis_tx_tlast;
  logic [63:0]   axis_tx_tdata;
  logic          done_serializer;

  serializer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .send_data_valid (send_data_valid),
    .v_data_read     (v_data_read),
    .dst_addr_send   (dst_addr_send),
    .TTL_send        (TTL_send),
    .router_id_send  (router_id_send),
    .axis_tx_tvalid  (axis_tx_tvalid),
    .axis_tx_tlast   (axis_tx_tlast),
    .axis_tx_tdata   (axis_tx_tdata),
    .done_serializer (done_serializer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t       sb[$];
  logic [63:0] cap[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          done_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: header fields, or 61 message bits per payload beat, zero past bit 1023.
  function automatic logic [63:0] exp_beat(input logic [1023:0] d, input logic [9:0] dst,
                                           input logic [1:0] ttl, input logic [1:0] rid, input int k);
    logic [63:0] r;
    logic [7:0]  x;
    r = '0;
    r[2:1] = rid;
    if (k == 0) begin
      r[0]     = 1'b1;
      r[12:3]  = dst;
      r[14:13] = ttl;
      x = 8'h00;
      for (int i = 0; i < 128; i++) x = x ^ d[i*8 +: 8];
`ifdef SERIALIZER_HDR_CHECKSUM_EN
      r[22:15] = x;
`endif
    end else begin
      for (int b = 0; b < 61; b++) begin
        int idx;
        idx = 61*(k-1) + b;
        if (idx < 1024) r[3+b] = d[idx];
      end
    end
    return r;
  endfunction

  initial begin
    bit          prev_tlast;
    int          run;
    beat_t       e;
    prev_tlast = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
        prev_tlast = 1'b0;
      end else begin
        if (axis_tx_tvalid) begin
          run++;
          cap.push_back(axis_tx_tdata);
          if (sb.size() == 0) begin
            chk("unexpected_beat", 64'(axis_tx_tvalid), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("tdata", axis_tx_tdata, e.data);
            chk("tlast", 64'(axis_tx_tlast), 64'(e.last));
          end
        end else begin
          chk("idle_tdata", axis_tx_tdata, 64'd0);
          chk("idle_tlast", 64'(axis_tx_tlast), 64'd0);
          if (run != 0) begin
            chk("valid_run_len", 64'(run), 64'd18);
            run = 0;
          end
        end
        if (done_serializer) begin
          done_cnt++;
          chk("done_after_tlast", 64'(prev_tlast), 64'd1);
          chk("done_tvalid", 64'(axis_tx_tvalid), 64'd0);
        end
        prev_tlast = axis_tx_tlast;
      end
    end
  end

  task automatic send_start(input logic [1023:0] d, input logic [9:0] dst,
                            input logic [1:0] ttl, input logic [1:0] rid);
    @(negedge clk);
    cap.delete();
    v_data_read     = d;
    dst_addr_send   = dst;
    TTL_send        = ttl;
    router_id_send  = rid;
    send_data_valid = 1'b1;
    for (int k = 0; k < 18; k++) sb.push_back('{data: exp_beat(d, dst, ttl, rid, k), last: (k == 17)});
    @(negedge clk);
    send_data_valid = 1'b0;
    chk("hdr_latency", 64'(axis_tx_tvalid), 64'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_serializer && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 64'(n < 40), 64'd1);
  endtask

  task automatic send_full(input logic [1023:0] d, input logic [9:0] dst,
                           input logic [1:0] ttl, input logic [1:0] rid);
    send_start(d, dst, ttl, rid);
    wait_done();
    chk("beat_count", 64'(cap.size()), 64'd18);
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [1023:0] d;
    int            dc;
    rst_n = 1'b0;
    send_data_valid = 1'b0;
    v_data_read = '0;
    dst_addr_send = '0;
    TTL_send = '0;
    router_id_send = '0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 64'(axis_tx_tvalid), 64'd0);
    chk("rst_tlast", 64'(axis_tx_tlast), 64'd0);
    chk("rst_tdata", axis_tx_tdata, 64'd0);
    chk("rst_done", 64'(done_serializer), 64'd0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 64; i++) d[16*i +: 16] = 16'h1111 * 16'((i % 9) + 1);
    send_full(d, 10'h00A, 2'd1, 2'd2);
`ifndef SERIALIZER_HDR_CHECKSUM_EN
    if (cap.size() == 18) chk("pat_header", cap[0], 64'h2055);
`endif
    for (int k = 1; k < cap.size(); k++) chk("pat_low_bits", 64'(cap[k][2:0]), 64'd4);

    d = {256{4'h5}};
    send_full(d, 10'h1AA, 2'd2, 2'd3);
    if (cap.size() == 18) begin
      chk("fives_header", cap[0], 64'h4D57);
      chk("fives_beat0", cap[1], 64'hAAAAAAAAAAAAAAAE);
      chk("fives_beat16", cap[17], 64'h0002AAAAAAAAAAAE);
`ifdef SERIALIZER_HDR_CHECKSUM_EN
      chk("fives_csum", 64'(cap[0][22:15]), 64'h00);
`endif
    end

    d = '0;
    d[7:0] = 8'hA5;
    send_full(d, 10'h3FF, 2'd3, 2'd1);
`ifdef SERIALIZER_HDR_CHECKSUM_EN
    if (cap.size() == 18) chk("a5_csum", 64'(cap[0][22:15]), 64'hA5);
`endif

    // Re-pulse in PAYLOAD and in DONE: neither may start or alter a message.
    for (int w = 0; w < 32; w++) d[32*w +: 32] = $urandom();
    dc = done_cnt;
    send_start(d, 10'h155, 2'd0, 2'd0);
    repeat (5) @(negedge clk);
    v_data_read = ~d;
    dst_addr_send = 10'h2AA;
    router_id_send = 2'd3;
    send_data_valid = 1'b1;
    @(negedge clk);
    send_data_valid = 1'b0;
    wait_done();
    send_data_valid = 1'b1;
    @(negedge clk);
    send_data_valid = 1'b0;
    repeat (25) @(negedge clk);
    chk("repulse_beats", 64'(cap.size()), 64'd18);
    chk("repulse_done_cnt", 64'(done_cnt - dc), 64'd1);

    // Reset while frame_count = 8.
    for (int w = 0; w < 32; w++) d[32*w +: 32] = $urandom();
    send_start(d, 10'h0F0, 2'd2, 2'd1);
    repeat (8) @(negedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_tvalid", 64'(axis_tx_tvalid), 64'd0);
    chk("midrst_tlast", 64'(axis_tx_tlast), 64'd0);
    chk("midrst_tdata", axis_tx_tdata, 64'd0);
    chk("midrst_done", 64'(done_serializer), 64'd0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    send_full(~d, 10'h00F, 2'd1, 2'd2);

    for (int m = 0; m < 3; m++) begin
      for (int w = 0; w < 32; w++) d[32*w +: 32] = $urandom();
      send_full(d, 10'($urandom()), 2'($urandom()), 2'($urandom()));
    end

    repeat (5) @(negedge clk);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
